programmable_timer: RTL

Parametrised down-counting timer generalising the lab 4-bit timer. It adds configurable width, a tick prescaler, one-shot and periodic modes, a busy flag and a visible count. A `load` strobe arms the timer, and `q` pulses for one clock on expiry. It sits beside the FSMs that need timed delays (blink rates, debounce windows, note durations).

---
 rtl/programmable_timer_pkg.sv | 13 +
 rtl/programmable_timer_tick_prescaler.sv | 38 +++
 rtl/programmable_timer.sv | 84 ++++++++
 3 files changed

// File: rtl/programmable_timer_pkg.sv
// Shared definitions for the programmable down-counting timer:
// mode encodings and FSM state type.
package programmable_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/programmable_timer_tick_prescaler.sv
// Prescaler for the timer: emits one tick every PRESCALE enabled clocks.
// clear restarts the phase; the counter holds while en is low.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  // With PRESCALE=1 the counter is a single bit that stays at zero.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/programmable_timer.sv
// Down-counting timer with prescaler, one-shot/periodic modes and a
// registered one-cycle expiry pulse on q.
module programmable_timer
  import programmable_timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             count_en,
  output logic             q,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic             tick;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(load),
    .en   ((state_q == ST_RUN) && count_en),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    pulse_d  = 1'b0;
    // A load wins over a same-cycle tick, so no pulse can escape it.
    if (load) begin
      reload_d = load_value;
      count_d  = load_value;
      mode_d   = mode;
      state_d  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        pulse_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      pulse_q  <= pulse_d;
    end
  end

  assign q     = pulse_q;
  assign busy  = (state_q == ST_RUN);
  assign count = count_q;

endmodule
